// File: rtl/datapath_pkg.sv
// ---------------------------------------------------------------------------
// datapath_pkg
// Shared width constants and the ALU operation encoding for the
// register-read / execute / write-back datapath slice.
// ---------------------------------------------------------------------------
package datapath_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int IMM_W  = 16;
    localparam int NREGS  = 2 ** ADDR_W;

    // Codes not listed here are legal inputs and produce a zero result.
    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_op_t;

endpackage

// File: rtl/regfile_alu_datapath_if.sv
// ---------------------------------------------------------------------------
// regfile_alu_datapath_if
// Bundle between instruction decode (master) and the datapath (slave).
//   master drives : ra, rb, rw, we, imm, src_sel, alu_ctrl
//   slave drives  : rd1, rd2, opb, result, overflow, zero
// ---------------------------------------------------------------------------
interface regfile_alu_datapath_if;
    import datapath_pkg::*;

    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rw;
    logic              we;
    logic [IMM_W-1:0]  imm;
    logic              src_sel;
    logic [3:0]        alu_ctrl;

    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] result;
    logic              overflow;
    logic              zero;

    modport master (
        output ra, rb, rw, we, imm, src_sel, alu_ctrl,
        input  rd1, rd2, opb, result, overflow, zero
    );

    modport slave (
        input  ra, rb, rw, we, imm, src_sel, alu_ctrl,
        output rd1, rd2, opb, result, overflow, zero
    );

endinterface

// File: rtl/dp_regfile.sv
// ---------------------------------------------------------------------------
// dp_regfile
// Two combinational read ports, one synchronous write port, async clear.
// Register 0 is hard-wired to zero: writes to it are dropped and reads of it
// return 0. Reads never see the value being written in the same cycle.
//   clk, rst_n : clock, asynchronous active-low clear of every register
//   ra, rb     : read addresses -> rd1, rd2
//   rw, we, wd : write address, enable, data (committed on rising clk)
// ---------------------------------------------------------------------------
module dp_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rw,
    input  logic              we,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [NREGS];

    // NOTE: the whole array is cleared in the async reset branch because the
    // datapath must guarantee every register reads 0 after reset; this keeps
    // it in flops rather than a RAM macro, which is what a 32x32 file wants.
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // which is also what makes reads in the write cycle return the old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rw != '0)) begin
            regs[rw] <= wd;
        end
    end

    assign rd1 = (ra == '0) ? '0 : regs[ra];
    assign rd2 = (rb == '0) ? '0 : regs[rb];

endmodule

// File: rtl/regfile_alu_datapath.sv
// ---------------------------------------------------------------------------
// regfile_alu_datapath
// Single-cycle read / execute / write-back slice. Operand A is read port 1,
// operand B is read port 2 or the sign-extended immediate. The ALU result is
// written back to register rw on the rising edge when we is high.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decode-side bundle (addresses, imm, controls in;
//                read data, operand B, result and flags out)
// ---------------------------------------------------------------------------
module regfile_alu_datapath
    import datapath_pkg::*;
#(
    parameter int P_DATA_W = DATA_W,
    parameter int P_ADDR_W = ADDR_W,
    parameter int P_NREGS  = NREGS,
    parameter int P_IMM_W  = IMM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_alu_datapath_if.slave bus
);

    logic [P_DATA_W-1:0] a;
    logic [P_DATA_W-1:0] b;
    logic [P_DATA_W-1:0] rd2;
    logic [P_DATA_W-1:0] immx;
    logic [P_DATA_W-1:0] sum;
    logic [P_DATA_W-1:0] diff;
    logic [P_DATA_W-1:0] result;
    logic                overflow;
    alu_op_t             op;

    dp_regfile #(
        .DATA_W (P_DATA_W),
        .ADDR_W (P_ADDR_W),
        .NREGS  (P_NREGS)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra    (bus.ra),
        .rb    (bus.rb),
        .rw    (bus.rw),
        .we    (bus.we),
        .wd    (result),
        .rd1   (a),
        .rd2   (rd2)
    );

    assign immx = {{(P_DATA_W-P_IMM_W){bus.imm[P_IMM_W-1]}}, bus.imm};
    assign b    = bus.src_sel ? immx : rd2;
    assign sum  = a + b;
    assign diff = a - b;
    assign op   = alu_op_t'(bus.alu_ctrl);

    // NOTE: result and overflow get defaults first so that an unlisted code
    // (or a missed assignment in some branch) can never infer a latch.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result   = sum;
                // Same-sign operands whose sum flips sign.
                overflow = (a[P_DATA_W-1] == b[P_DATA_W-1]) &&
                           (sum[P_DATA_W-1] != a[P_DATA_W-1]);
            end
            ALU_SUB: begin
                result   = diff;
                // Opposite-sign operands whose difference leaves A's sign.
                overflow = (a[P_DATA_W-1] != b[P_DATA_W-1]) &&
                           (diff[P_DATA_W-1] != a[P_DATA_W-1]);
            end
            ALU_SLT: result = {{(P_DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign bus.rd1      = a;
    assign bus.rd2      = rd2;
    assign bus.opb      = b;
    assign bus.result   = result;
    assign bus.overflow = overflow;
    assign bus.zero     = (result == '0);

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// ---------------------------------------------------------------------------
// tb_regfile_alu_datapath
// Directed table of spec vectors, hand sequences for the multi-cycle corners
// (r0 writes, we=0, no bypass, async reset) and random traffic, all compared
// against a behavioural model: an array of 32 words and integer arithmetic.
// ---------------------------------------------------------------------------
module tb_regfile_alu_datapath;
    import datapath_pkg::*;

    logic clk;
    logic rst_n;

    regfile_alu_datapath_if bus ();

    regfile_alu_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_regs [32];

    typedef struct {
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic        we;
        logic [15:0] imm;
        logic        src_sel;
        logic [3:0]  alu_ctrl;
        logic [31:0] exp_result;
        logic        exp_ovf;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ALU from arithmetic rules, using 64-bit signed integers.
    function automatic void model_alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] op,
                                      output logic [31:0] r, output logic ovf);
        longint sa;
        longint sb;
        longint s;
        sa  = $signed(a);
        sb  = $signed(b);
        r   = 32'd0;
        ovf = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                s   = sa + sb;
                r   = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                s   = sa - sb;
                r   = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: r = ~(a | b);
            default: r = 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                         input logic we, input logic [15:0] imm, input logic src_sel,
                         input logic [3:0] alu_ctrl);
        bus.ra       = ra;
        bus.rb       = rb;
        bus.rw       = rw;
        bus.we       = we;
        bus.imm      = imm;
        bus.src_sel  = src_sel;
        bus.alu_ctrl = alu_ctrl;
        #1;
    endtask

    // Compare every output with the model, then clock once and update the model.
    task automatic model_check_step(input string tag);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] immx;
        logic [31:0] r;
        logic        ovf;
        a    = model_regs[bus.ra];
        immx = 32'($signed(bus.imm));
        b    = bus.src_sel ? immx : model_regs[bus.rb];
        model_alu(a, b, bus.alu_ctrl, r, ovf);
        check({tag, " rd1"}, bus.rd1, a);
        check({tag, " rd2"}, bus.rd2, model_regs[bus.rb]);
        check({tag, " opb"}, bus.opb, b);
        check({tag, " result"}, bus.result, r);
        check({tag, " overflow"}, 32'(bus.overflow), 32'(ovf));
        check({tag, " zero"}, 32'(bus.zero), 32'(r == 32'd0));
        @(posedge clk);
        if (rst_n && bus.we && bus.rw != 5'd0) model_regs[bus.rw] = r;
        @(negedge clk);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        drive(v.ra, v.rb, v.rw, v.we, v.imm, v.src_sel, v.alu_ctrl);
        check({tag, " tbl result"}, bus.result, v.exp_result);
        check({tag, " tbl overflow"}, 32'(bus.overflow), 32'(v.exp_ovf));
        check({tag, " tbl zero"}, 32'(bus.zero), 32'(v.exp_zero));
        model_check_step(tag);
    endtask

    function automatic vec_t mk(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                                input logic we, input logic [15:0] imm, input logic src_sel,
                                input logic [3:0] op, input logic [31:0] res,
                                input logic ovf, input logic z);
        vec_t v;
        v.ra = ra; v.rb = rb; v.rw = rw; v.we = we; v.imm = imm;
        v.src_sel = src_sel; v.alu_ctrl = op;
        v.exp_result = res; v.exp_ovf = ovf; v.exp_zero = z;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

        // Basic table: r1 = 3, r2 = FFFFFFFF, then register-register ops.
        vecs.push_back(mk(0, 5, 0, 0, 16'h0000, 0, 4'd0,  32'h00000000, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0003, 1, 4'd2,  32'h00000003, 0, 0));
        vecs.push_back(mk(0, 0, 2, 1, 16'hFFFF, 1, 4'd2,  32'hFFFFFFFF, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 16'h0000, 0, 4'd0,  32'h00000003, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 16'h0000, 0, 4'd1,  32'hFFFFFFFF, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 16'h0000, 0, 4'd12, 32'h00000000, 0, 1));
        vecs.push_back(mk(1, 2, 0, 0, 16'h0000, 0, 4'd6,  32'h00000004, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 16'h0000, 0, 4'd7,  32'h00000000, 0, 1));
        vecs.push_back(mk(2, 1, 0, 0, 16'h0000, 0, 4'd7,  32'h00000001, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0001, 1, 4'd2,  32'h00000004, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 16'h0000, 0, 4'd5,  32'h00000000, 0, 1));

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 0, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // r3 = 0x4000, doubled 17 times -> 0x80000000 (last step overflows).
        drive(0, 0, 3, 1, 16'h4000, 1, 4'd2);
        model_check_step("load r3");
        for (int i = 0; i < 17; i++) begin
            drive(3, 3, 3, 1, 16'h0, 0, 4'd2);
            model_check_step($sformatf("dbl%0d", i));
        end
        check("r3 built", model_regs[3], 32'h80000000);
        // SUB 80000000 - 1 -> 7FFFFFFF into r4, ADD 7FFFFFFF + 1 -> 80000000.
        apply_vec(mk(3, 0, 4, 1, 16'h0001, 1, 4'd6, 32'h7FFFFFFF, 1, 0), "sub ovf");
        apply_vec(mk(4, 0, 0, 0, 16'h0001, 1, 4'd2, 32'h80000000, 1, 0), "add ovf");

        // Writes to r0 are dropped.
        drive(0, 0, 0, 1, 16'h0005, 1, 4'd2);
        check("r0 wr result", bus.result, 32'h5);
        model_check_step("r0 wr");
        drive(0, 0, 0, 0, 16'h0, 0, 4'd1);
        check("r0 reads 0", bus.rd1, 32'h0);

        // we=0 leaves r4 unchanged.
        drive(0, 0, 4, 0, 16'h0055, 1, 4'd2);
        model_check_step("we0");
        drive(4, 0, 0, 0, 16'h0, 0, 4'd0);
        check("r4 kept", bus.rd1, 32'h7FFFFFFF);

        // ra == rb == rw: old value during the cycle, new value after.
        drive(1, 1, 1, 1, 16'h0001, 1, 4'd2);
        check("nobypass rd1", bus.rd1, 32'h3);
        check("nobypass rd2", bus.rd2, 32'h3);
        model_check_step("same addr");
        drive(1, 1, 0, 0, 16'h0, 0, 4'd0);
        check("after wb rd1", bus.rd1, 32'h4);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            case ($urandom_range(0, 7))
                0: op = 4'd0;  1: op = 4'd1;  2: op = 4'd2;  3: op = 4'd6;
                4: op = 4'd7;  5: op = 4'd12; 6: op = 4'd2;
                default: op = 4'($urandom_range(0, 15));
            endcase
            drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                  16'($urandom), 1'($urandom), op);
            model_check_step($sformatf("rnd%0d", i));
        end

        // Async reset mid-cycle: r1 is nonzero, clears without a clock edge.
        drive(0, 0, 1, 1, 16'h0003, 1, 4'd2);
        model_check_step("r1=3");
        drive(1, 0, 0, 0, 16'h0, 0, 4'd0);
        check("pre reset rd1", bus.rd1, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("async clear rd1", bus.rd1, 32'h0);
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        // Clock edge while in reset with a pending write must not write.
        drive(0, 0, 5, 1, 16'h0009, 1, 4'd2);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(5, 1, 0, 0, 16'h0, 0, 4'd1);
        check("no write in reset", bus.rd1, 32'h0);
        model_check_step("post reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_alu_datapath.md
Name: regfile_alu_datapath

Overview:
- Single-cycle register-read / execute / write-back datapath slice.
- Two combinational register reads feed a 32-bit ALU. The B operand comes from a mux: read port 2 or a sign-extended 16-bit immediate.
- The ALU result is written back to the register file on the clock edge.
- Sits between instruction decode (which supplies addresses, immediate and control) and the rest of the CPU core.

Parameters:
- DATA_W, 32, datapath and register width.
- ADDR_W, 5, register address width.
- NREGS, 32, number of registers (2**ADDR_W).
- IMM_W, 16, immediate width before sign extension.

Ports:
- clk  in  1  system clock; all writes occur on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra  in  ADDR_W  read address, port 1 (ALU operand A).
- rb  in  ADDR_W  read address, port 2.
- rw  in  ADDR_W  write-back register address.
- we  in  1  write-back enable.
- imm  in  IMM_W  immediate operand.
- src_sel  in  1  B-operand select: 0 = read port 2, 1 = sign-extended imm.
- alu_ctrl  in  4  ALU operation code.
- rd1  out  DATA_W  register read data, port 1.
- rd2  out  DATA_W  register read data, port 2.
- opb  out  DATA_W  mux output (ALU operand B).
- result  out  DATA_W  ALU result (also the write-back data).
- overflow  out  1  signed overflow flag.
- zero  out  1  high when result == 0.

Behaviour:
- Reset: rst_n low asynchronously clears all NREGS registers to 0. While reset is asserted, no write occurs.
- Register 0:
  - Always reads 0.
  - Writes to address 0 are discarded.
- Reads:
  - rd1 = reg[ra] and rd2 = reg[rb], purely combinational.
  - No write-to-read bypass: a read of rw during its write cycle returns the old value until after the edge.
- Immediate:
  - immx = sign extension of imm (bit 15 replicated into bits 31..16).
  - Example: 16'h0001 gives 32'h00000001; 16'hFFFF gives 32'hFFFFFFFF.
- Mux: opb = src_sel ? immx : rd2.
- ALU (combinational, A = rd1, B = opb):
  - 0: A AND B.
  - 1: A OR B.
  - 2: A + B, modulo 2^32.
  - 6: A − B, modulo 2^32.
  - 7: set-less-than, signed. Result = 1 if A < B (two's complement), else 0.
  - 12: NOR, ~(A | B).
  - Any other code: result = 0.
- overflow:
  - add: high when A and B have the same sign and the result sign differs.
  - sub: high when A and B have different signs and the result sign differs from A.
  - Always 0 for every other code.
  - Combinational and unregistered.
- zero: (result == 0), combinational.
- Write-back: on rising clk with rst_n high, we high and rw != 0, reg[rw] <= result.
- Latency: result, flags and opb are valid combinationally in the same cycle; the written value is visible on rd1/rd2 from the next cycle.
- ra == rb == rw in one cycle is legal. Both reads return the pre-edge value, and the register updates at the edge.
- Reset asserted mid-cycle clears immediately and overrides any pending write.

Decomposition:
- Shared package, datapath_pkg:
  - Width constants DATA_W, ADDR_W, IMM_W.
  - Enum alu_op_t with ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12.
- One natural sub-module: dp_regfile, the 2-read/1-write register array with async reset.
- The ALU, sign extension and mux stay inline in the top module.

Test Plan:
- Reset, then ra=0, rb=5 -> rd1=0, rd2=0, result=0 (op AND), zero=1, overflow=0.
- ADD immediate: ra=0, imm=16'h0003, src_sel=1, alu_ctrl=2, rw=1, we=1, one clock -> result=3 during the cycle; rd1 with ra=1 reads 3 next cycle. Repeat with imm=16'hFFFF into r2 -> r2=32'hFFFFFFFF.
- Register ops with src_sel=0, ra=1 (3), rb=2 (FFFFFFFF):
  - AND -> 3.
  - OR -> FFFFFFFF.
  - NOR -> 0 with zero=1.
  - SUB -> 4.
  - SLT -> 0; swapping ra/rb -> 1.
- Overflow:
  - r3=7FFFFFFF (built via imm 7FFF and shifts is not available, so load through ADD of two registers); ADD r3+immx(1) -> 80000000, overflow=1.
  - SUB 80000000 − 1 -> 7FFFFFFF, overflow=1.
  - ADD 3+1 -> overflow=0.
- Write to r0: rw=0, we=1, result=5 -> r0 still reads 0. With we=0, writing rw=4 leaves r4 unchanged.
- Async reset mid-cycle with r1=3: drop rst_n between edges -> rd1 (ra=1) goes 0 immediately. A clock edge during reset with we=1 writes nothing.
